// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared LFSR width, default taps, checker state type
// and the next-state function used by generator and checker.
package lfsr_pkg;

  localparam int LFSR_W = 8;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'hB8;
  localparam int LFSR_MAX_W = 32;

  typedef enum logic {
    SYNC,
    LOCKED
  } chk_state_t;

  // Callers zero-extend cur and a W-bit tap mask, then keep
  // the low W bits: that equals {cur[W-2:0], ^(cur & taps)}.
  function automatic logic [LFSR_MAX_W-1:0] lfsr_next(
    input logic [LFSR_MAX_W-1:0] cur,
    input logic [LFSR_MAX_W-1:0] taps
  );
    return {cur[LFSR_MAX_W-2:0], ^(cur & taps)};
  endfunction

endpackage

// File: rtl/lfsr_predictor.sv
// lfsr_predictor: holds the expected next LFSR word.
// Ports: clk, reset (sync, active-low), load/load_val, step, exp_val.
module lfsr_predictor
  import lfsr_pkg::*;
#(
  parameter int W = LFSR_W,
  parameter logic [W-1:0] TAPS = LFSR_TAPS
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         step,
  output logic [W-1:0] exp_val
);

  logic [W-1:0] exp_q;
  logic [W-1:0] exp_d;

  always_comb begin
    exp_d = exp_q;
    if (load) begin
      exp_d = W'(lfsr_next(32'(load_val), 32'(TAPS)));
    end else if (step) begin
      exp_d = W'(lfsr_next(32'(exp_q), 32'(TAPS)));
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      exp_q <= '0;
    end else begin
      exp_q <= exp_d;
    end
  end

  assign exp_val = exp_q;

endmodule

// File: rtl/lfsr_checker.sv
// lfsr_checker: self-syncing LFSR receive checker, error count, period.
// Ports: clk, reset, in_valid, in_data, err_clear -> locked, err_*, period*.
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int W = LFSR_W,
  parameter logic [W-1:0] TAPS = LFSR_TAPS,
  parameter int LOSS_THRESH = 4,
  parameter int ERR_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [W-1:0]     in_data,
  input  logic             err_clear,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic [W:0]       period,
  output logic             period_valid,
  output logic             maximal
);

  localparam int MISS_W = $clog2(LOSS_THRESH + 1);
  localparam logic [W:0] PERIOD_MAX = {1'b0, {W{1'b1}}};

  chk_state_t state_q, state_d;
  logic [W-1:0] ref_q, ref_d;
  logic [W:0] cnt_q, cnt_d;
  logic [MISS_W-1:0] miss_q, miss_d, miss_inc;
  logic [ERR_W-1:0] err_q, err_d;
  logic pulse_q, pulse_d;
  logic [W:0] period_q, period_d;
  logic pv_q, pv_d;
  logic max_q, max_d;

  logic pred_load;
  logic pred_step;
  logic [W-1:0] exp_val;

  lfsr_predictor #(
    .W   (W),
    .TAPS(TAPS)
  ) u_pred (
    .clk     (clk),
    .reset   (reset),
    .load    (pred_load),
    .load_val(in_data),
    .step    (pred_step),
    .exp_val (exp_val)
  );

  always_comb begin
    state_d = state_q;
    ref_d = ref_q;
    cnt_d = cnt_q;
    miss_d = miss_q;
    err_d = err_q;
    pulse_d = 1'b0;
    period_d = period_q;
    pv_d = pv_q;
    pred_load = 1'b0;
    pred_step = 1'b0;
    miss_inc = miss_q + 1'b1;
    if (in_valid) begin
      unique case (state_q)
        SYNC: begin
          // all-zero is the lock-up word; never seed from it
          if (in_data != '0) begin
            pred_load = 1'b1;
            ref_d = in_data;
            cnt_d = '0;
            miss_d = '0;
            pv_d = 1'b0;
            state_d = LOCKED;
          end
        end
        LOCKED: begin
          pred_step = 1'b1;
          if (cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
          end
          if (in_data == exp_val) begin
            miss_d = '0;
            if (in_data == ref_q && !pv_q) begin
              period_d = cnt_q + 1'b1;
              pv_d = 1'b1;
            end
          end else begin
            pulse_d = 1'b1;
            if (err_q != '1) begin
              err_d = err_q + 1'b1;
            end
            miss_d = miss_inc;
            if (miss_inc == MISS_W'(LOSS_THRESH)) begin
              state_d = SYNC;
              pv_d = 1'b0;
            end
          end
        end
        default: state_d = SYNC;
      endcase
    end
    if (err_clear) begin
      err_d = '0;
    end
    max_d = pv_d && (period_d == PERIOD_MAX);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= SYNC;
      ref_q <= '0;
      cnt_q <= '0;
      miss_q <= '0;
      err_q <= '0;
      pulse_q <= 1'b0;
      period_q <= '0;
      pv_q <= 1'b0;
      max_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ref_q <= ref_d;
      cnt_q <= cnt_d;
      miss_q <= miss_d;
      err_q <= err_d;
      pulse_q <= pulse_d;
      period_q <= period_d;
      pv_q <= pv_d;
      max_q <= max_d;
    end
  end

  assign locked = (state_q == LOCKED);
  assign err_pulse = pulse_q;
  assign err_count = err_q;
  assign period = period_q;
  assign period_valid = pv_q;
  assign maximal = max_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// tb_lfsr_checker: random + directed stimulus, scoreboard against
// a sequence-index model of the checker.
module tb_lfsr_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic err_clear = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic locked, err_pulse, period_valid, maximal;
  logic [15:0] err_count;
  logic [8:0] period;

  lfsr_checker dut (
    .clk         (clk),
    .reset       (rst_n),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .err_clear   (err_clear),
    .locked      (locked),
    .err_pulse   (err_pulse),
    .err_count   (err_count),
    .period      (period),
    .period_valid(period_valid),
    .maximal     (maximal)
  );

  typedef struct packed {
    logic locked;
    logic pulse;
    logic [15:0] err;
    logic [8:0] period;
    logic pv;
    logic maximal;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int checks = 0;
  int errors = 0;
  int cycles = 0;

  logic [7:0] seq[255];
  int idx_of[256];

  bit m_lock, m_pv, m_pulse;
  int m_ref_idx, m_n, m_miss, m_err, m_period;

  function automatic logic [7:0] gold_next(logic [7:0] v);
    int p;
    p = $countones(v & 8'hB8);
    return 8'((int'(v) * 2 + p % 2) % 256);
  endfunction

  function automatic logic [7:0] gold(int k);
    return seq[k % 255];
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t",
               name, act, exp, $time);
    end
  endtask

  task automatic model(bit v, logic [7:0] d, bit clr, bit rst);
    logic [7:0] ev;
    int n_old;
    if (!rst) begin
      m_lock = 0; m_pv = 0; m_pulse = 0; m_n = 0;
      m_miss = 0; m_err = 0; m_period = 0; m_ref_idx = 0;
    end else begin
      m_pulse = 0;
      if (v) begin
        if (!m_lock) begin
          if (d != 8'h00) begin
            m_lock = 1; m_ref_idx = idx_of[d];
            m_n = 0; m_miss = 0; m_pv = 0;
          end
        end else begin
          ev = seq[(m_ref_idx + m_n + 1) % 255];
          n_old = m_n;
          m_n++;
          if (d == ev) begin
            m_miss = 0;
            if (d == seq[m_ref_idx] && !m_pv) begin
              m_period = ((n_old > 511 ? 511 : n_old) + 1) % 512;
              m_pv = 1;
            end
          end else begin
            m_pulse = 1;
            if (m_err < 65535) m_err++;
            m_miss++;
            if (m_miss == 4) begin
              m_lock = 0;
              m_pv = 0;
            end
          end
        end
      end
      if (clr) m_err = 0;
    end
  endtask

  task automatic drive(bit v, logic [7:0] d, bit clr, bit rst);
    exp_t e;
    @(negedge clk);
    in_valid = v;
    in_data = d;
    err_clear = clr;
    rst_n = rst;
    model(v, d, clr, rst);
    e.locked = m_lock;
    e.pulse = m_pulse;
    e.err = 16'(m_err);
    e.period = 9'(m_period);
    e.pv = m_pv;
    e.maximal = m_pv && (m_period == 255);
    sbq.push_back(e);
    cycles++;
  endtask

  task automatic do_reset();
    repeat (2) drive(0, 8'h00, 0, 0);
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    #1;
    if (sbq.size() != 0) begin
      mon_e = sbq.pop_front();
      chk("locked", int'(locked), int'(mon_e.locked));
      chk("err_pulse", int'(err_pulse), int'(mon_e.pulse));
      chk("err_count", int'(err_count), int'(mon_e.err));
      chk("period", int'(period), int'(mon_e.period));
      chk("period_valid", int'(period_valid), int'(mon_e.pv));
      chk("maximal", int'(maximal), int'(mon_e.maximal));
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p, b;
    bit v, clr, rst;
    logic [7:0] d;
    int pos;

    seq[0] = 8'h01;
    idx_of[0] = -1;
    for (int i = 1; i < 255; i++) seq[i] = gold_next(seq[i-1]);
    for (int i = 0; i < 255; i++) idx_of[seq[i]] = i;

    // clean stream from seed 01
    do_reset();
    settle();
    chk("rst_locked", int'(locked), 0);
    chk("rst_err", int'(err_count), 0);
    for (int i = 0; i < 260; i++) drive(1, gold(i), 0, 1);
    settle();
    chk("s1_period", int'(period), 255);
    chk("s1_maximal", int'(maximal), 1);
    chk("s1_err", int'(err_count), 0);

    // single corrupted word
    do_reset();
    for (int i = 0; i < 300; i++)
      drive(1, gold(i) ^ (i == 40 ? 8'h10 : 8'h00), 0, 1);
    settle();
    chk("s2_err", int'(err_count), 1);
    chk("s2_locked", int'(locked), 1);

    // four FF words drop lock, then relock
    p = 60;
    while (gold(p) == 8'hFF || gold(p+1) == 8'hFF ||
           gold(p+2) == 8'hFF || gold(p+3) == 8'hFF) p++;
    do_reset();
    for (int i = 0; i < 300; i++) begin
      drive(1, (i >= p && i < p + 4) ? 8'hFF : gold(i), 0, 1);
      if (i == p + 3) begin
        settle();
        chk("s3_lost", int'(locked), 0);
        chk("s3_err4", int'(err_count), 4);
      end
    end
    settle();
    chk("s3_relock", int'(locked), 1);
    chk("s3_err_kept", int'(err_count), 4);

    // zeros ignored in SYNC
    do_reset();
    drive(1, 8'h00, 0, 1);
    drive(1, 8'h00, 0, 1);
    settle();
    chk("s4_zero_sync", int'(locked), 0);
    b = idx_of[8'h5A];
    for (int i = 0; i < 260; i++) drive(1, gold(b + i), 0, 1);
    settle();
    chk("s4_period", int'(period), 255);

    // valid toggling
    do_reset();
    for (int i = 0; i < 520; i++) begin
      if (i % 2 == 0) drive(1, gold(i / 2), 0, 1);
      else drive(0, 8'($urandom), 0, 1);
    end
    settle();
    chk("s5_period", int'(period), 255);
    chk("s5_maximal", int'(maximal), 1);

    // reset mid-stream
    do_reset();
    for (int i = 0; i < 100; i++)
      drive(1, gold(i) ^ ((i == 30 || i == 50) ? 8'h04 : 8'h00), 0, 1);
    settle();
    chk("s6_err2", int'(err_count), 2);
    drive(1, gold(100), 0, 0);
    settle();
    chk("s6_rst_lock", int'(locked), 0);
    chk("s6_rst_err", int'(err_count), 0);
    chk("s6_rst_pv", int'(period_valid), 0);
    chk("s6_rst_per", int'(period), 0);
    for (int i = 0; i < 260; i++) drive(1, gold(i), 0, 1);
    settle();
    chk("s6_period", int'(period), 255);

    // clear beats a simultaneous mismatch
    do_reset();
    for (int i = 0; i < 50; i++) begin
      drive(1, gold(i) ^ ((i == 20 || i == 30) ? 8'h21 : 8'h00),
            (i == 20 || i == 40), 1);
      if (i == 20) begin
        settle();
        chk("s7_clr_win", int'(err_count), 0);
        chk("s7_pulse", int'(err_pulse), 1);
      end
      if (i == 30) begin
        settle();
        chk("s7_err1", int'(err_count), 1);
      end
    end
    settle();
    chk("s7_clr", int'(err_count), 0);

    // random traffic
    do_reset();
    pos = $urandom_range(0, 254);
    for (int i = 0; i < 3000; i++) begin
      v = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 499) != 0);
      clr = ($urandom_range(0, 99) == 0);
      d = 8'($urandom);
      if (v) begin
        d = gold(pos);
        pos++;
        if ($urandom_range(0, 29) == 0) d = d ^ 8'($urandom);
        if ($urandom_range(0, 199) == 0) d = 8'h00;
      end
      drive(v, d, clr, rst);
    end

    repeat (2) @(posedge clk);
    #3;
    chk("sb_drain", sbq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/lfsr_checker.md
Name: lfsr_checker

Overview:
- Receive-side companion to the 8-bit Fibonacci LFSR generator. Consumes one `shift_seed`-style word per valid cycle and self-synchronises by loading the first non-zero sample.
- Predicts each following word using the same polynomial. Flags and counts mismatches.
- Measures the sequence period and reports whether it is maximal (2^W-1).
- Used in the PRBS loopback path and as a synthesizable replacement for bench-side period checks.

Parameters:
- W, 8, LFSR/sample width in bits.
- TAPS, 8'hB8, feedback tap mask: fb = ^(cur & TAPS); next = {cur[W-2:0], fb}. Default taps are bits 7,5,4,3, which is maximal.
- LOSS_THRESH, 4, number of consecutive mismatches that drops lock.
- ERR_W, 16, width of the error counter (saturating).

Ports:
- clk, input, 1, system clock; all state updates on posedge.
- reset, input, 1, synchronous active-low reset (reset==0 clears everything on the next posedge).
- in_valid, input, 1, in_data is a new LFSR word this cycle.
- in_data, input, W, received LFSR word.
- err_clear, input, 1, synchronous clear of err_count only.
- locked, output, 1, checker is in LOCKED state.
- err_pulse, output, 1, one-cycle pulse for each mismatching sample while locked.
- err_count, output, ERR_W, saturating mismatch count.
- period, output, W+1, measured repeat distance in samples.
- period_valid, output, 1, period has been captured (sticky until resync/reset).
- maximal, output, 1, period_valid && period == 2^W-1.

Behaviour:
- Reset (reset==0 at posedge): state=SYNC; expected=0; ref=0; cnt=0; miss=0. All outputs 0.
- All outputs are registered and reflect a sample one cycle after it is presented.
- Cycles with in_valid==0 change no state; err_pulse is 0 on those cycles.

SYNC state:
- On in_valid with in_data!=0: ref<=in_data; expected<=next(in_data); cnt<=0; miss<=0; period_valid<=0; go to LOCKED.
- On in_valid with in_data==0 (lock-up value): ignored; stay in SYNC.

LOCKED state, each valid sample:
- cnt<=cnt+1, saturating at 2^(W+1)-1.
- expected<=next(expected). The predictor free-runs and does not reseed on error, so a single corrupted word counts exactly once.
- Match (in_data==expected): miss<=0. If in_data==ref and !period_valid, then period<=cnt+1 and period_valid<=1.
- Mismatch: err_pulse<=1; err_count increments (saturates at all-ones); miss<=miss+1.
- Loss of lock: if miss+1==LOSS_THRESH, go to SYNC, locked<=0, period_valid<=0. err_count is retained.

Error counter:
- err_clear and a mismatch in the same cycle: the clear wins, err_count<=0.

Example:
- With default TAPS, seed 8'h01 arriving as the first sample, the 255th subsequent sample equals 8'h01.
- Result: period=255, maximal=1.

Other rules:
- Reset mid-operation aborts immediately; no partial period is reported.
- locked is high from the cycle after the lock sample.

Decomposition:
- Package lfsr_pkg holds:
  - LFSR_W=8 and LFSR_TAPS=8'hB8 (shared with the generator);
  - typedef enum logic {SYNC, LOCKED} chk_state_t;
  - function lfsr_next(cur, taps).
- One sub-module, lfsr_predictor: holds expected, with load (value) and step (valid) controls, and outputs the current expected value. It reuses lfsr_next so generator and checker cannot diverge.

Test Plan:
- Golden LFSR model seeded 8'h01, in_valid=1 continuously -> locked=1 one cycle after first sample; after 255 further samples period=255, period_valid=1, maximal=1, err_count=0.
- Same stream with sample #40 XORed by 8'h10 -> one err_pulse, err_count=1, locked stays 1, no further errors.
- Replace 4 consecutive samples with 8'hFF -> err_count=4, locked drops after the 4th; resynchronises on the next valid non-zero sample; err_count stays 4.
- First samples 8'h00, 8'h00, then 8'h5A -> stays in SYNC for the zeros; locks on 8'h5A.
- in_valid toggling 1/0 every cycle with seed 8'h01 -> period still 255, maximal=1 after ~510 cycles.
- Reset (reset=0) asserted at sample 100 with err_count=2, then the stream restarts -> all outputs 0 the next cycle, full relock, period=255.
- err_clear asserted in the same cycle as a mismatch -> err_count=0.
